// File: rtl/compare_search_pkg.sv
// Shared definitions for the binary-search controller and the comparator side:
// FSM state encoding and the {gt,eq,lt} flag vectors.
package compare_search_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        PROBE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/compare_search_step.sv
// Combinational search step: narrows [lo, hi] around the current probe from one
// comparator result and decides whether the search terminates.
module compare_search_step
    import compare_search_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] probe,
    input  logic [2:0]       flags,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next,
    output logic             terminate,
    output logic             found,
    output logic             err
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        lo_next   = lo;
        hi_next   = hi;
        terminate = 1'b0;
        found     = 1'b0;
        err       = 1'b0;
        case (flags)
            CMP_EQ: begin
                terminate = 1'b1;
                found     = 1'b1;
            end
            // The probe==lo / probe==hi exits also keep probe-1 and probe+1 from wrapping.
            CMP_GT: begin
                if (probe == lo) terminate = 1'b1;
                else             hi_next   = probe - 1'b1;
            end
            CMP_LT: begin
                if (probe == hi) terminate = 1'b1;
                else             lo_next   = probe + 1'b1;
            end
            default: begin
                terminate = 1'b1;
                err       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/compare_search.sv
// Binary-search controller: walks [lo_init, hi_init] by presenting probes to an
// external comparator until it hits the target, exhausts the range or sees bad flags.
module compare_search
    import compare_search_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            lo_init,
    input  logic [WIDTH-1:0]            hi_init,
    output logic [WIDTH-1:0]            probe,
    output logic                        probe_valid,
    input  logic                        cmp_valid,
    input  logic                        gt,
    input  logic                        eq,
    input  logic                        lt,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic                        err,
    output logic [WIDTH-1:0]            result,
    output logic [$clog2(WIDTH+2)-1:0]  probes
);

    localparam int PW = $clog2(WIDTH + 2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH-1:0] probe_q, probe_d, result_q, result_d;
    logic [PW-1:0]    probes_q, probes_d;
    logic             probe_valid_q, probe_valid_d, busy_q, busy_d, done_q, done_d;
    logic             found_q, found_d, err_q, err_d;

    logic [WIDTH-1:0] step_lo, step_hi;
    logic             step_term, step_found, step_err;

    compare_search_step #(.WIDTH(WIDTH)) u_step (
        .lo        (lo_q),
        .hi        (hi_q),
        .probe     (probe_q),
        .flags     ({gt, eq, lt}),
        .lo_next   (step_lo),
        .hi_next   (step_hi),
        .terminate (step_term),
        .found     (step_found),
        .err       (step_err)
    );

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        result_d = result_q;
        probes_d = probes_q;
        found_d  = found_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d     = lo_init;
                    hi_d     = hi_init;
                    probes_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (lo_q > hi_q) begin
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    // Midpoint in WIDTH+1 bits so hi-lo near full range cannot overflow.
                    probe_d = WIDTH'({1'b0, lo_q} + (({1'b0, hi_q} - {1'b0, lo_q}) >> 1));
                    state_d = PROBE;
                end
            end
            PROBE: begin
                if (cmp_valid) begin
                    probes_d = probes_q + 1'b1;
                    lo_d     = step_lo;
                    hi_d     = step_hi;
                    if (step_term) begin
                        found_d  = step_found;
                        err_d    = step_err;
                        result_d = step_found ? probe_q : '0;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered copies of the next state, so they align with state_q.
        probe_valid_d = (state_d == PROBE);
        busy_d        = (state_d == CALC) || (state_d == PROBE);
        done_d        = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lo_q          <= '0;
            hi_q          <= '0;
            probe_q       <= '0;
            result_q      <= '0;
            probes_q      <= '0;
            probe_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            probe_q       <= probe_d;
            result_q      <= result_d;
            probes_q      <= probes_d;
            probe_valid_q <= probe_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            found_q       <= found_d;
            err_q         <= err_d;
        end
    end

    assign probe       = probe_q;
    assign probe_valid = probe_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign err         = err_q;
    assign result      = result_q;
    assign probes      = probes_q;

endmodule

// File: tb/tb_compare_search.sv
// Directed bench for compare_search (WIDTH=8) with a behavioural comparator driven
// from the bench; expected probe sequences and outcomes are hand-computed.
module tb_compare_search;
    import compare_search_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst, start, cmp_valid, gt, eq, lt;
    logic [W-1:0] lo_init, hi_init, probe, result;
    logic         probe_valid, busy, done, found, err;
    logic [3:0]   probes;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [7:0]   seen[$];
    logic [7:0]   exp_q[$];
    int           cyc_done;
    logic         pv_seen, stable_ok;

    compare_search #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .lo_init     (lo_init),
        .hi_init     (hi_init),
        .probe       (probe),
        .probe_valid (probe_valid),
        .cmp_valid   (cmp_valid),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .err         (err),
        .result      (result),
        .probes      (probes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    endtask

    function automatic logic [2:0] cmp_flags(input logic [7:0] p, input logic [7:0] t);
        if (p > t)       return CMP_GT;
        else if (p == t) return CMP_EQ;
        else             return CMP_LT;
    endfunction

    // Runs one search; comparator answers after wait_cyc idle PROBE cycles,
    // and the bad_at-th result (1-based, 0 = never) carries flags 3'b110.
    task automatic do_search(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                             input logic [7:0] tgt, input int wait_cyc, input int bad_at);
        int         cyc, wait_cnt, n_res;
        logic [7:0] held;
        seen.delete();
        pv_seen   = 1'b0;
        stable_ok = 1'b1;
        wait_cnt  = 0;
        n_res     = 0;
        held      = '0;
        @(negedge clk);
        lo_init = lo;
        hi_init = hi;
        start   = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        cmp_valid = 1'b0;
        {gt, eq, lt} = 3'b000;
        while (!done && cyc < 400) begin
            if (probe_valid) begin
                pv_seen = 1'b1;
                if (wait_cnt == 0)       held = probe;
                else if (probe !== held) stable_ok = 1'b0;
                if (wait_cnt == wait_cyc) begin
                    n_res++;
                    cmp_valid    = 1'b1;
                    {gt, eq, lt} = (n_res == bad_at) ? 3'b110 : cmp_flags(probe, tgt);
                    seen.push_back(probe);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
            cyc++;
            cmp_valid    = 1'b0;
            {gt, eq, lt} = 3'b000;
        end
        cyc_done = cyc;
        check({tag, "_done_reached"}, done, 1);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_nres"}, seen.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++)
            check($sformatf("%s_p%0d", tag, i), seen[i], exp_q[i]);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        lo_init   = '0;
        hi_init   = '0;
        cmp_valid = 1'b0;
        {gt, eq, lt} = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_probe", probe, 0);
        check("rst_pv", probe_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_probes", probes, 0);
        rst = 1'b0;

        // Full range, target 0x00: walks down the left edge.
        do_search("t1", 8'd0, 8'd255, 8'h00, 0, 0);
        exp_q = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
        check_seq("t1");
        check("t1_found", found, 1);
        check("t1_err", err, 0);
        check("t1_result", result, 0);
        check("t1_probes", probes, 8);
        check("t1_cycles", cyc_done, 17);
        check("t1_busy_at_done", busy, 0);
        // A start during the DONE cycle must be ignored.
        lo_init = 8'd0;
        hi_init = 8'd255;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_done_pulse", done, 0);
        check("t1_start_in_done_ignored", busy, 0);
        check("t1_found_held", found, 1);

        // Full range, target 0xFF: walks up to the top, needs WIDTH+1 results.
        do_search("t2", 8'd0, 8'd255, 8'hFF, 0, 0);
        exp_q = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
        check_seq("t2");
        check("t2_found", found, 1);
        check("t2_result", result, 255);
        check("t2_probes", probes, 9);
        check("t2_cycles", cyc_done, 19);
        @(negedge clk);
        check("t2_probe_hold", probe, 255);
        check("t2_pv_idle", probe_valid, 0);

        // Target below the window: terminates on probe==lo with gt.
        do_search("t3", 8'd10, 8'd20, 8'd5, 0, 0);
        exp_q = '{8'd15, 8'd12, 8'd10};
        check_seq("t3");
        check("t3_found", found, 0);
        check("t3_err", err, 0);
        check("t3_probes", probes, 3);
        check("t3_result", result, 0);
        @(negedge clk);

        // Empty window lo>hi: straight from CALC to DONE.
        do_search("t4", 8'd9, 8'd3, 8'd5, 0, 0);
        check("t4_cycles", cyc_done, 2);
        check("t4_found", found, 0);
        check("t4_err", err, 0);
        check("t4_probes", probes, 0);
        check("t4_no_pv", pv_seen, 0);
        @(negedge clk);

        // Slow comparator with a non-one-hot flag vector on the 2nd result.
        do_search("t5", 8'd0, 8'd255, 8'h5A, 3, 2);
        exp_q = '{8'd127, 8'd63};
        check_seq("t5");
        check("t5_stable", stable_ok, 1);
        check("t5_err", err, 1);
        check("t5_found", found, 0);
        check("t5_probes", probes, 2);
        check("t5_result", result, 0);
        @(negedge clk);

        // Stray start while busy, then reset in the middle of PROBE.
        lo_init = 8'd0;
        hi_init = 8'd255;
        start   = 1'b1;
        @(negedge clk);
        lo_init = 8'd200;
        hi_init = 8'd210;
        check("t6_busy_calc", busy, 1);
        @(negedge clk);
        start = 1'b0;
        check("t6_pv", probe_valid, 1);
        check("t6_stray_start_ignored", probe, 127);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_probe", probe, 0);
        check("t6_rst_pv", probe_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_probes", probes, 0);
        check("t6_rst_found", found, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_result", result, 0);

        do_search("t7", 8'd0, 8'd255, 8'h5A, 0, 0);
        exp_q = '{8'd127, 8'd63, 8'd95, 8'd79, 8'd87, 8'd91, 8'd89, 8'd90};
        check_seq("t7");
        check("t7_found", found, 1);
        check("t7_err", err, 0);
        check("t7_result", result, 8'h5A);
        check("t7_probes", probes, 8);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/compare_search.md
COMPARE_SEARCH -- requirements
Module: compare_search

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand/probe width in bits.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a search; sampled only in IDLE.
REQ-005 lo_init  input  WIDTH  inclusive lower search bound, sampled with start.
REQ-006 hi_init  input  WIDTH  inclusive upper search bound, sampled with start.
REQ-007 probe  output  WIDTH  operand presented to the external comparator (probe vs hidden target).
REQ-008 probe_valid  output  1  probe is stable and a compare result is requested.
REQ-009 cmp_valid  input  1  comparator result valid this cycle.
REQ-010 gt, eq, lt  input  1 each  comparator flags: probe>target, probe==target, probe<target.
REQ-011 busy  output  1  high from the cycle after accepted start until done.
REQ-012 done  output  1  single-cycle pulse when the search ends.
REQ-013 found, err  output  1 each  outcome flags, valid with done and held until next start.
REQ-014 result  output  WIDTH  matching probe when found=1, else 0.
REQ-015 probes  output  $clog2(WIDTH+2)  number of compare results consumed by the last/current search.

Function
REQ-016 FSM states SHALL be IDLE, CALC, PROBE, DONE.
REQ-017 IDLE: start=1 SHALL latch lo=lo_init and hi=hi_init, clear probes, found, err and result, and go to CALC; start is ignored in every other state.
REQ-018 CALC: if lo>hi, go to DONE with found=0, err=0; otherwise compute probe = lo + ((hi-lo)>>1) in WIDTH+1 bits (no overflow) and go to PROBE.
REQ-019 PROBE: probe_valid=1 and probe is held constant until cmp_valid=1; each cmp_valid cycle increments probes.
REQ-020 On cmp_valid with eq only: found=1, result=probe, go to DONE.
REQ-021 On cmp_valid with gt only: if probe==lo go to DONE with found=0; else hi=probe-1, go to CALC.
REQ-022 On cmp_valid with lt only: if probe==hi go to DONE with found=0; else lo=probe+1, go to CALC.
REQ-023 On cmp_valid with flags not exactly one-hot: err=1, found=0, go to DONE.
REQ-024 DONE SHALL assert done for exactly one cycle and return to IDLE; a start in that cycle is ignored.
REQ-025 With a zero-wait comparator, each iteration SHALL take 2 cycles (CALC+PROBE); a full-range search SHALL consume at most WIDTH+1 results.
REQ-026 probe_valid SHALL be 0 outside PROBE; probe SHALL hold its last value outside PROBE.

Reset
REQ-027 rst SHALL force IDLE and clear probe, probe_valid, busy, done, found, err, result, probes and internal lo/hi to 0, including mid-search; the next cycle accepts start normally.

Structure
REQ-028 Package compare_search_pkg SHALL hold the state enum and the flag encoding constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001 (order {gt,eq,lt}), shared with the comparator side.
REQ-029 One combinational sub-module, compare_search_step, SHALL compute next lo/hi, terminate and err from (lo, hi, probe, flags); the FSM and registers stay in compare_search.

Verification (WIDTH=8, behavioural comparator, cmp_valid same cycle as probe_valid unless stated)
REQ-030 lo_init=0, hi_init=255, target 0x00 -> probes 127,63,31,15,7,3,1,0; done with found=1, result=0, probes=8.
REQ-031 Same bounds, target 0xFF -> probes 127,191,223,239,247,251,253,254,255; found=1, probes=9.
REQ-032 lo_init=10, hi_init=20, target 5 -> probes 15,12,10; done found=0, err=0, probes=3, result=0.
REQ-033 lo_init=9, hi_init=3 -> done 2 cycles after start, found=0, probes=0, probe_valid never asserted.
REQ-034 Target 0x5A, cmp_valid delayed 3 cycles per probe; a flag vector of 3'b110 injected on the 2nd result -> probe stable while waiting, err=1, found=0, probes=2.
REQ-035 rst asserted during PROBE, and start asserted while busy -> outputs zero after reset and the stray start is ignored; a new search then completes correctly for target 0x5A.
